encoder_16to4_stream: RTL
=========================

Name: encoder_16to4_stream

Overview:
- Streaming encoder, the inverse of the team's one-hot decoders.
- Accepts a 16-bit bit-mask on a valid/ready input handshake.
- Emits the 4-bit binary index of every set bit, lowest index first, one index per output handshake.
- Marks the final index with a last flag.
- Used to turn decoded select/request vectors back into index streams for downstream units.

Parameters:
- WIDTH, 16, mask width. Block is verified only at 16.
- IDX_W, 4, index width. Must equal clog2(WIDTH).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in carries a mask to accept.
- in_ready  output  1  block can accept a mask this cycle.
- in  input  WIDTH  mask to encode.
- out_valid  output  1  out holds a valid index.
- out_ready  input  1  downstream accepts out this cycle.
- out  output  IDX_W  binary index of the current lowest remaining set bit.
- out_last  output  1  current index is the final set bit of the mask.
- empty  output  1  one-cycle pulse: a zero mask was accepted.

Behaviour:
- Interface: one clock, clk. Reset is rst, synchronous and active-high.
- Reset (rst=1 at an edge):
  - state=IDLE, held mask=0.
  - Next cycle: out_valid=0, out=0, out_last=0, empty=0.
  - in_ready=0 in any cycle where rst=1. rst overrides all handshakes.
- States: IDLE, EMIT.
- IDLE:
  - in_ready=1, out_valid=0, out=0, out_last=0.
  - Accept occurs on in_valid && in_ready at an edge; the mask is captured from in.
  - Nonzero mask: go to EMIT.
  - Zero mask: stay IDLE; empty=1 for exactly the next cycle; in_ready stays 1.
  - Back-to-back zero masks pulse empty on consecutive cycles.
- EMIT:
  - in_ready=0, out_valid=1. in_valid is ignored and nothing is captured.
  - out = index of the lowest set bit of the held mask (combinational priority encode of the registered mask).
  - out_last=1 iff exactly one bit remains set.
  - Output handshake (out_valid && out_ready at an edge) clears that bit in the held mask.
  - If the handshake happens with out_last=1: go to IDLE, so in_ready=1 the following cycle.
  - out_ready=0: mask, out and out_last hold stable indefinitely (AXI-style, no retraction).
- Latency:
  - First index is valid in the cycle after accept.
  - Throughput is 1 index/cycle with out_ready held high.
  - A mask with N set bits occupies the block for N cycles after the accept edge.
  - No overlap: the next mask can be accepted no earlier than the cycle after the last handshake.
- empty: never asserted in EMIT; never asserted together with out_valid.
- Reset mid-EMIT: remaining indices are discarded, no further out_valid, block is IDLE after release.
- Bits of in beyond WIDTH do not exist. Index arithmetic is unsigned, IDX_W wide, with no wrap (max index 15).

Test Plan:
- rst held 2 cycles, then released:
  - out_valid=0, out=0, out_last=0, empty=0 throughout.
  - in_ready=0 during rst and =1 the first cycle after release.
- in=16'h8000 accepted, out_ready=1:
  - Next cycle out_valid=1, out=15, out_last=1.
  - Following cycle out_valid=0, in_ready=1.
- in=16'h8421, out_ready=1:
  - out=0,5,10,15 on 4 consecutive cycles, out_last=1 only with 15.
  - in_ready=0 across all 4 cycles; an in_valid pulse with 16'hFFFF during them is ignored.
- in=16'h0022, out_ready=0 for 3 cycles after first valid:
  - out=1 held stable with out_valid=1, out_last=0 for those 3 cycles.
  - Then out_ready=1 gives out=1, then out=5 with out_last=1.
- in=16'h0000 accepted twice back-to-back:
  - empty=1 on each of the two following cycles.
  - out_valid never asserted; in_ready=1 throughout.
- in=16'hFFFF, out_ready=1, rst asserted after the 6th output handshake (out=5):
  - Next cycle out_valid=0, in_ready=0.
  - After release in_ready=1 and no further indices appear.
  - A fresh 16'h0001 then yields out=0, out_last=1.

Source files
------------

// File: rtl/encoder_16to4_stream.sv
// Streaming mask-to-index encoder: accepts a WIDTH-bit mask and emits the index
// of each set bit, lowest first, one per output handshake, flagging the final one.
module encoder_16to4_stream #(
  parameter int WIDTH = 16,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out,
  output logic             out_last,
  output logic             empty
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             empty_q, empty_d;
  logic [IDX_W-1:0] low_idx;
  logic [WIDTH-1:0] mask_rest;
  logic             one_left;

  // Scan high to low so the lowest set bit is the one that sticks.
  always_comb begin
    low_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--)
      if (mask_q[i]) low_idx = IDX_W'(i);
  end

  assign mask_rest = mask_q & (mask_q - WIDTH'(1));
  assign one_left  = (mask_q != '0) && (mask_rest == '0);

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    empty_d   = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out       = '0;
    out_last  = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = !rst;
        if (in_valid) begin
          mask_d = in;
          if (in == '0) empty_d = 1'b1;
          else          state_d = EMIT;
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        out       = low_idx;
        out_last  = one_left;
        if (out_ready) begin
          mask_d = mask_rest;
          if (one_left) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mask_q  <= '0;
      empty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      empty_q <= empty_d;
    end
  end

  assign empty = empty_q;

endmodule
